// File: rtl/lsu_bus_port.sv
// Load/store bus port: runs one aligned 64-bit access at a time on a single-outstanding
// request/response bus, with range check and response timeout. Optional macro: LSU_LINE_BUFFER_EN.
module lsu_bus_port #(
  parameter int unsigned       XLEN    = 64,
  parameter int unsigned       ADDR_W  = 61,
  parameter logic [ADDR_W-1:0] MEM_TOP = 61'h0000_0000_1000_0000,
  parameter int unsigned       TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_prev_stalled,
  output logic              lsu_stall_next,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_do_load,
  input  logic              lsu_do_store,
  input  logic [XLEN-1:0]   lsu_store_data,
  input  logic [XLEN/8-1:0] lsu_store_mask,
  output logic [XLEN-1:0]   lsu_load_data,
  output logic              lsu_access_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  input  logic              mem_resp_error
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wmask_q, wmask_d;
  logic [XLEN-1:0]     load_data_q, load_data_d;
  logic                fault_q, fault_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                stale_q, stale_d;
  logic                accept;

`ifdef LSU_LINE_BUFFER_EN
  logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
  logic [XLEN-1:0]     buf_data_q, buf_data_d;
  logic                buf_valid_q, buf_valid_d;
  logic                buf_hit;

  assign buf_hit = lsu_do_load && buf_valid_q && (buf_tag_q == lsu_addr);
`endif

  assign accept = !lsu_prev_stalled && (lsu_do_load ^ lsu_do_store);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    stale_d     = stale_q;
`ifdef LSU_LINE_BUFFER_EN
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
`endif
    // The first response after a timeout belongs to the abandoned request.
    if (mem_resp_valid && stale_q) stale_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = lsu_addr;
          write_d = lsu_do_store;
          wdata_d = lsu_store_data;
          wmask_d = lsu_store_mask;
          fault_d = 1'b0;
`ifdef LSU_LINE_BUFFER_EN
          if (lsu_do_store && buf_tag_q == lsu_addr) buf_valid_d = 1'b0;
`endif
          if (lsu_addr >= MEM_TOP) begin
            fault_d = 1'b1;
            state_d = StDone;
`ifdef LSU_LINE_BUFFER_EN
            buf_valid_d = 1'b0;
          end else if (buf_hit) begin
            load_data_d = buf_data_q;
            state_d     = StDone;
`endif
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_resp_valid && !stale_q) begin
          if (!write_q) load_data_d = mem_resp_data;
          fault_d = mem_resp_error;
          state_d = StDone;
`ifdef LSU_LINE_BUFFER_EN
          if (mem_resp_error) begin
            buf_valid_d = 1'b0;
          end else if (!write_q) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = mem_resp_data;
          end
`endif
        end else if (cnt_d == 8'(TIMEOUT)) begin
          fault_d = 1'b1;
          stale_d = 1'b1;
          state_d = StDone;
`ifdef LSU_LINE_BUFFER_EN
          buf_valid_d = 1'b0;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      stale_q     <= stale_d;
    end
  end

`ifdef LSU_LINE_BUFFER_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

  assign lsu_stall_next   = (state_q != StDone);
  assign lsu_access_fault = (state_q == StDone) && fault_q;
  assign lsu_load_data    = load_data_q;
  assign mem_req_valid    = (state_q == StReq);
  assign mem_req_addr     = addr_q;
  assign mem_req_write    = write_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_req_wmask    = wmask_q;

`ifndef SYNTHESIS
  // Requests are only legal while idle.
  prev_stalled_idle_a : assert property (@(posedge clk) disable iff (!rst)
    !lsu_prev_stalled |-> state_q == StIdle);
`endif

endmodule

// File: doc/lsu_bus_port.md
Name: lsu_bus_port

Overview:
- Load/store unit directly downstream of the execute-stage memory unit. Takes one aligned 64-bit access per handshake (`lsu_*` signals) and runs it on a single-outstanding memory bus request/response port.
- Returns the load data and an access-fault flag to the execute stage.
- Enforces a physical address range check and a response timeout. Either one produces an access fault instead of a hang.

Parameters:
- XLEN, 64, data width; must be 64 (8 byte lanes).
- ADDR_W, 61, aligned (8-byte granule) address width.
- MEM_TOP, 61'h0000_0000_1000_0000, first aligned address that faults; accesses at or above it never reach the bus.
- TIMEOUT, 255, max cycles waiting in RESP before a fault (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset (0 = reset)
- lsu_prev_stalled  in  1  0 = request presented this cycle
- lsu_stall_next  out  1  0 (single cycle) = access complete; data/fault valid this cycle
- lsu_addr  in  ADDR_W  aligned access address
- lsu_do_load  in  1  load request
- lsu_do_store  in  1  store request
- lsu_store_data  in  XLEN  store data, lane-replicated
- lsu_store_mask  in  XLEN/8  byte enables
- lsu_load_data  out  XLEN  full aligned doubleword read
- lsu_access_fault  out  1  access fault, qualified by lsu_stall_next=0
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  ADDR_W  request address
- mem_req_write  out  1  1 = store
- mem_req_wdata  out  XLEN  store data
- mem_req_wmask  out  XLEN/8  byte enables
- mem_resp_valid  in  1  response valid (one per accepted request)
- mem_resp_data  in  XLEN  read data
- mem_resp_error  in  1  bus error

Behaviour:
- **Reset values** (rst=0 sampled at posedge): state IDLE, lsu_stall_next=1, lsu_access_fault=0, lsu_load_data=0, mem_req_valid=0, timeout counter 0, stale flag 0. Reset mid-operation abandons the access and never signals completion for it.
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE:**
  - Accept when lsu_prev_stalled=0 and exactly one of do_load/do_store is 1.
  - Register addr, write, data and mask.
  - If addr >= MEM_TOP, go to DONE with fault=1 and no bus activity. Otherwise go to REQ.
  - prev_stalled=0 with neither or both op bits set: ignored, stay IDLE.
- **REQ:**
  - mem_req_valid=1; addr/write/wdata/wmask held stable until mem_req_ready=1.
  - On the ready cycle go to RESP and clear the counter.
  - mem_req_valid drops the cycle after acceptance.
- **RESP:**
  - Counter increments each cycle.
  - mem_resp_valid=1: capture data (loads only; stores leave lsu_load_data unchanged), fault=mem_resp_error, go to DONE.
  - If the counter reaches TIMEOUT with no response: fault=1, stale=1, go to DONE.
- **DONE:** lsu_stall_next=0 for exactly one cycle with lsu_load_data/lsu_access_fault valid, then IDLE.
- **Latency:** request at cycle N. With ready at N+1 and response at N+2, lsu_stall_next=0 at N+3. A range fault completes at N+1.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after DONE (needed for the AMO store following its load).
- lsu_prev_stalled=0 while not IDLE is a protocol violation: ignored, with a simulation assertion.
- **Stale response:** while stale=1, the next mem_resp_valid in any state is dropped and clears stale. A new request may be issued while stale=1, but responses are matched in order, so the first response is consumed as the stale one.
- mem_resp_valid in IDLE with stale=0 is ignored.
- lsu_access_fault is held at 0 except in DONE.

Optional Feature:
- Macro LSU_LINE_BUFFER_EN.
- **When defined:** one-entry read buffer (tag, data, valid).
  - A load whose addr matches the valid tag goes IDLE->DONE with the buffered data and fault=0 (completion at N+1, no bus request).
  - A successful load response fills the buffer.
  - Any accepted store to the matching tag invalidates the buffer, as does any fault or reset.
- **When undefined:** every in-range access uses the bus; latency as above.

Test Plan:
- Load addr 0x10, ready at N+1, resp data 64'h0123_4567_89AB_CDEF at N+2 -> stall_next=0 at N+3, load_data=64'h0123_4567_89AB_CDEF, fault=0.
- Store addr 0x20, data 64'hFF, mask 8'h01, ready held 0 for 3 cycles -> mem_req_* stable for 4 cycles; one-cycle completion after the response, fault=0.
- Load addr MEM_TOP -> mem_req_valid never asserts; stall_next=0 at N+1 with fault=1.
- Load whose response never arrives -> fault=1 completion after TIMEOUT=255 cycles in RESP. A response arriving later is dropped. The next load returns its own data.
- Load with mem_resp_error=1 -> fault=1. A store immediately in the IDLE cycle after DONE is accepted.
- rst=0 while in RESP -> next cycle mem_req_valid=0, stall_next=1, no completion.
- LSU_LINE_BUFFER_EN defined:
  - Second load to 0x10 completes at N+1 with no bus request.
  - After a store to 0x10, the next load to 0x10 goes to the bus.
